// File: rtl/maxpool_window_sched_if.sv
// -----------------------------------------------------------------------------
// maxpool_window_sched_if
//
// Bundles the pixel-stream handshake and the pooling-datapath control bus of
// the 2x2 / stride-2 max-pool window sequencer.
//
// Signals:
//   In_Valid   upstream pixel valid
//   In_Ready   sequencer can accept a pixel
//   Lb_Addr    partial-max line-buffer slot (col >> 1)
//   Lb_Wr_En   write the partial max back into Lb_Addr
//   Win_Load   first pixel of a window: load without compare
//   Win_Cmp    compare pixel with the stored partial max
//   Out_Valid  window result valid on the datapath output
//
// Modports:
//   slave   the sequencer: sinks the pixel stream, drives the datapath controls
//   master  the surrounding logic: sources the pixel stream, observes controls
// -----------------------------------------------------------------------------
interface maxpool_window_sched_if #(
    parameter int unsigned COL_WIDTH = 14
);

    logic                 In_Valid;
    logic                 In_Ready;
    logic [COL_WIDTH-2:0] Lb_Addr;
    logic                 Lb_Wr_En;
    logic                 Win_Load;
    logic                 Win_Cmp;
    logic                 Out_Valid;

    modport slave (
        input  In_Valid,
        output In_Ready,
        output Lb_Addr,
        output Lb_Wr_En,
        output Win_Load,
        output Win_Cmp,
        output Out_Valid
    );

    modport master (
        output In_Valid,
        input  In_Ready,
        input  Lb_Addr,
        input  Lb_Wr_En,
        input  Win_Load,
        input  Win_Cmp,
        input  Out_Valid
    );

endinterface

// File: rtl/maxpool_window_sched.sv
// -----------------------------------------------------------------------------
// maxpool_window_sched
//
// Sequencer for the 2x2, stride-2 max-pooling datapath. Accepts a raster-scan
// pixel stream, tracks the column/row position of every accepted pixel and
// drives the partial-max line buffer controls. Each completed window is flagged
// with a registered Out_Valid; frame start, completion and rejected
// configurations are reported on Busy / Done / Cfg_Err.
//
// Ports:
//   Clk         clock
//   Rst         asynchronous, active-low reset
//   Start       one-cycle frame start request (honoured only when idle)
//   Img_Width   pixels per row, sampled on an accepted Start
//   Img_Height  rows per frame, sampled on an accepted Start
//   pix         pixel handshake + datapath controls (slave modport)
//   Busy        frame in progress
//   Done        one-cycle pulse at end of frame
//   Cfg_Err     one-cycle pulse when a Start is rejected
// -----------------------------------------------------------------------------
module maxpool_window_sched #(
    parameter int unsigned COL_WIDTH = 14,
    parameter int unsigned ROW_WIDTH = 14
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [COL_WIDTH-1:0] Img_Width,
    input  logic [ROW_WIDTH-1:0] Img_Height,
    maxpool_window_sched_if.slave pix,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Cfg_Err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [COL_WIDTH-1:0] col_q, col_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [COL_WIDTH-1:0] w_q, w_d;
    logic [ROW_WIDTH-1:0] h_q, h_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cfg_err_q, cfg_err_d;

    logic in_ready;
    logic acc;
    logic col_last;
    logic row_last;
    logic cfg_ok;
    logic win_last_px;
    logic win_load;

    // Windows must tile the frame exactly, so both dimensions must be even
    // and at least one window wide/tall.
    assign cfg_ok = (Img_Width >= COL_WIDTH'(2)) && !Img_Width[0] &&
                    (Img_Height >= ROW_WIDTH'(2)) && !Img_Height[0];

    assign acc      = pix.In_Valid & in_ready;
    assign col_last = (col_q == w_q - COL_WIDTH'(1));
    assign row_last = (row_q == h_q - ROW_WIDTH'(1));

    // Odd row and odd column: bottom-right pixel, which closes its window.
    assign win_last_px = row_q[0] & col_q[0];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start && cfg_ok) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (acc && col_last && row_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b0;
            end
            StRun: begin
                in_ready = 1'b1;
                Busy     = 1'b1;
            end
            StDone: begin
                Done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Position counters, latched frame size and registered pulses
    // -------------------------------------------------------------------------
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        w_d         = w_q;
        h_d         = h_q;
        out_valid_d = acc & win_last_px;
        cfg_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (cfg_ok) begin
                        w_d   = Img_Width;
                        h_d   = Img_Height;
                        col_d = '0;
                        row_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (acc) begin
                    if (col_last) begin
                        col_d = '0;
                        // Wrap row on the final pixel so it never reaches H.
                        row_d = row_last ? '0 : row_q + ROW_WIDTH'(1);
                    end else begin
                        col_d = col_q + COL_WIDTH'(1);
                    end
                end
            end
            StDone: begin
                col_d = '0;
                row_d = '0;
            end
            default: begin
                col_d = '0;
                row_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_q       <= '0;
            row_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            w_q         <= w_d;
            h_q         <= h_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-pixel datapath controls
    // -------------------------------------------------------------------------
    // Top-left pixel of a window seeds the partial max; all others compare.
    assign win_load = acc & ~row_q[0] & ~col_q[0];

    assign pix.In_Ready  = in_ready;
    assign pix.Lb_Addr   = col_q[COL_WIDTH-1:1];
    assign pix.Win_Load  = win_load;
    assign pix.Win_Cmp   = acc & ~win_load;
    // The closing pixel's result goes straight out, not back into the buffer.
    assign pix.Lb_Wr_En  = acc & ~win_last_px;
    assign pix.Out_Valid = out_valid_q;

    assign Cfg_Err = cfg_err_q;

endmodule

// File: tb/tb_maxpool_window_sched.sv
// -----------------------------------------------------------------------------
// tb_maxpool_window_sched
//
// Self-checking bench for maxpool_window_sched. The reference model counts
// accepted pixels k within a frame and derives row = k / W, col = k % W; all
// expected controls, window pulses and Done follow from those positions.
// -----------------------------------------------------------------------------
module tb_maxpool_window_sched;

    localparam int unsigned ColW = 14;
    localparam int unsigned RowW = 14;

    logic            Clk;
    logic            Rst;
    logic            Start;
    logic [ColW-1:0] Img_Width;
    logic [RowW-1:0] Img_Height;
    logic            Busy;
    logic            Done;
    logic            Cfg_Err;

    int n_checks = 0;
    int n_fail   = 0;

    maxpool_window_sched_if #(.COL_WIDTH(ColW)) pix ();

    maxpool_window_sched #(
        .COL_WIDTH(ColW),
        .ROW_WIDTH(RowW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Img_Width (Img_Width),
        .Img_Height(Img_Height),
        .pix       (pix),
        .Busy      (Busy),
        .Done      (Done),
        .Cfg_Err   (Cfg_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  32'(pix.In_Ready),  0);
        check({tag, ".lb_addr"},   32'(pix.Lb_Addr),   0);
        check({tag, ".lb_wr_en"},  32'(pix.Lb_Wr_En),  0);
        check({tag, ".win_load"},  32'(pix.Win_Load),  0);
        check({tag, ".win_cmp"},   32'(pix.Win_Cmp),   0);
        check({tag, ".out_valid"}, 32'(pix.Out_Valid), 0);
        check({tag, ".busy"},      32'(Busy),          0);
        check({tag, ".done"},      32'(Done),          0);
        check({tag, ".cfg_err"},   32'(Cfg_Err),       0);
    endtask

    // Rejected Start: Cfg_Err pulses once, the block never becomes busy and
    // a valid pixel offered meanwhile is not taken.
    task automatic bad_start(input int w, input int h);
        @(negedge Clk);
        Start        = 1'b1;
        Img_Width    = ColW'(w);
        Img_Height   = RowW'(h);
        pix.In_Valid = 1'b1;
        #1;
        check("bad.in_ready_idle", 32'(pix.In_Ready), 0);
        check("bad.win_load_idle", 32'(pix.Win_Load), 0);
        @(negedge Clk);
        Start = 1'b0;
        check("bad.cfg_err", 32'(Cfg_Err), 1);
        check("bad.busy", 32'(Busy), 0);
        check("bad.in_ready", 32'(pix.In_Ready), 0);
        @(negedge Clk);
        check("bad.cfg_err_clear", 32'(Cfg_Err), 0);
        check("bad.busy_after", 32'(Busy), 0);
        pix.In_Valid = 1'b0;
    endtask

    // mode 0: back-to-back, 1: bubble every third cycle, 2: random bubbles.
    // abort_at >= 0 drops Rst once that many pixels have been accepted.
    // start_noise toggles Start with a different width while running.
    task automatic run_frame(input int w, input int h, input int mode, input int abort_at,
                             input bit start_noise);
        int k        = 0;
        int outs     = 0;
        int cyc      = 0;
        int r        = 0;
        int c        = 0;
        bit v        = 1'b0;
        bit exp_ov   = 1'b0;
        bit exp_done = 1'b0;
        bit finished = 1'b0;
        bit aborted  = 1'b0;

        @(negedge Clk);
        Start      = 1'b1;
        Img_Width  = ColW'(w);
        Img_Height = RowW'(h);
        @(negedge Clk);
        Start = 1'b0;

        while (cyc < w * h * 4 + 20) begin
            check("frm.out_valid", 32'(pix.Out_Valid), 32'(exp_ov));
            if (pix.Out_Valid === 1'b1) outs++;
            check("frm.done", 32'(Done), 32'(exp_done));
            check("frm.busy", 32'(Busy), 32'(!exp_done));
            check("frm.in_ready", 32'(pix.In_Ready), 32'(!exp_done));
            if (exp_done) begin
                finished     = 1'b1;
                Start        = 1'b0;
                pix.In_Valid = 1'b0;
                break;
            end
            if (abort_at >= 0 && k == abort_at) begin
                aborted = 1'b1;
                Rst     = 1'b0;
                #1;
                check_all_zero("abort");
                break;
            end

            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3) != 2;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            pix.In_Valid = v;
            if (start_noise) begin
                Start     = 1'($urandom_range(0, 1));
                Img_Width = ColW'(8);
            end
            #1;

            r = k / w;
            c = k % w;
            if (v) begin
                check("px.lb_addr", 32'(pix.Lb_Addr), 32'(c / 2));
                check("px.win_load", 32'(pix.Win_Load), 32'((r % 2 == 0) && (c % 2 == 0)));
                check("px.win_cmp", 32'(pix.Win_Cmp), 32'(!((r % 2 == 0) && (c % 2 == 0))));
                check("px.lb_wr_en", 32'(pix.Lb_Wr_En), 32'(!((r % 2 == 1) && (c % 2 == 1))));
            end else begin
                check("bub.win_load", 32'(pix.Win_Load), 0);
                check("bub.win_cmp", 32'(pix.Win_Cmp), 0);
                check("bub.lb_wr_en", 32'(pix.Lb_Wr_En), 0);
                check("bub.lb_addr_hold", 32'(pix.Lb_Addr), 32'(c / 2));
            end

            exp_ov   = v && (r % 2 == 1) && (c % 2 == 1);
            exp_done = v && (k == w * h - 1);
            if (v) k++;
            cyc++;
            @(negedge Clk);
        end

        if (aborted) begin
            pix.In_Valid = 1'b0;
            Start        = 1'b0;
            @(negedge Clk);
            check("abort.done_held", 32'(Done), 0);
            check("abort.busy_held", 32'(Busy), 0);
            check("abort.ov_held", 32'(pix.Out_Valid), 0);
            Rst = 1'b1;
            @(negedge Clk);
            check("abort.done_after", 32'(Done), 0);
            check("abort.busy_after", 32'(Busy), 0);
        end else begin
            check("frm.finished", 32'(finished), 1);
            check("frm.window_count", 32'(outs), 32'((w / 2) * (h / 2)));
            @(negedge Clk);
            check("idle.busy", 32'(Busy), 0);
            check("idle.done", 32'(Done), 0);
            check("idle.out_valid", 32'(pix.Out_Valid), 0);
            check("idle.in_ready", 32'(pix.In_Ready), 0);
        end
    endtask

    initial begin
        int w;
        int h;

        Rst          = 1'b0;
        Start        = 1'b0;
        Img_Width    = '0;
        Img_Height   = '0;
        pix.In_Valid = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b1;

        // 4x4 back-to-back, then with a bubble every third cycle
        run_frame(4, 4, 0, -1, 1'b0);
        run_frame(4, 4, 1, -1, 1'b0);

        // Rejected configurations
        bad_start(3, 4);
        bad_start(0, 4);
        bad_start(4, 1);
        bad_start(2 * $urandom_range(1, 20) + 1, 2 * $urandom_range(1, 20));
        bad_start(2 * $urandom_range(1, 20), 2 * $urandom_range(1, 20) + 1);

        // Smallest frame, with Start/width noise while running
        run_frame(2, 2, 0, -1, 1'b1);

        // Reset after pixel 9, then a clean 2x2 frame
        run_frame(4, 4, 0, 10, 1'b0);
        run_frame(2, 2, 0, -1, 1'b0);

        // Reset with a window result pending (right after pixel 7)
        run_frame(4, 4, 2, 8, 1'b0);
        run_frame(4, 2, 2, -1, 1'b0);

        // Random even sizes with random bubbles
        for (int i = 0; i < 6; i++) begin
            w = 2 * $urandom_range(1, 6);
            h = 2 * $urandom_range(1, 5);
            run_frame(w, h, 2, -1, (i % 2) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_window_sched.md
Name: maxpool_window_sched

Overview:
- Sequencer for the 2x2, stride-2 max-pooling datapath.
- Accepts a raster-scan pixel stream under a valid/ready handshake and tracks column and row position.
- Drives the pooling datapath's partial-max line buffer with address, write, load and compare controls.
- Flags each completed window and reports frame start, completion and configuration errors.

Parameters:
- COL_WIDTH, 14, width of the column counter and of Img_Width.
- ROW_WIDTH, 14, width of the row counter and of Img_Height.

Ports:
- Clk  input  1  clock.
- Rst  input  1  reset, asynchronous, active-low.
- Start  input  1  one-cycle frame start request.
- Img_Width  input  COL_WIDTH  pixels per row; sampled on an accepted Start.
- Img_Height  input  ROW_WIDTH  rows per frame; sampled on an accepted Start.
- In_Valid  input  1  upstream pixel valid.
- In_Ready  output  1  block can accept a pixel.
- Lb_Addr  output  COL_WIDTH-1  line-buffer slot, equal to col>>1.
- Lb_Wr_En  output  1  write the partial max into Lb_Addr.
- Win_Load  output  1  first pixel of a window: datapath loads the pixel and does not compare.
- Win_Cmp  output  1  datapath compares the pixel with the stored partial max.
- Out_Valid  output  1  window result valid on the datapath output.
- Busy  output  1  frame in progress.
- Done  output  1  one-cycle pulse at end of frame.
- Cfg_Err  output  1  one-cycle pulse when a Start is rejected.

Behaviour:
- Reset: state IDLE; col, row and latched W/H = 0. In_Ready, Lb_Wr_En, Win_Load, Win_Cmp, Out_Valid, Busy, Done and Cfg_Err = 0; Lb_Addr = 0.
- Acc = In_Valid & In_Ready. Pixels are counted only on Acc.

State IDLE:
- In_Ready = 0.
- On Start:
  - If Img_Width < 2, Img_Height < 2, or either value is odd: Cfg_Err = 1 on the next cycle; stay in IDLE.
  - Otherwise: latch W and H, clear col and row, go to RUN.
- In_Valid is ignored.

State RUN:
- Busy = 1, In_Ready = 1.
- Start is ignored and W/H are not re-sampled.

Per-pixel controls (combinational, asserted only when Acc):
- Lb_Addr = col[COL_WIDTH-1:1].
- Win_Load = Acc & !row[0] & !col[0].
- Win_Cmp = Acc & !Win_Load.
- Lb_Wr_En = Acc & !(row[0] & col[0]). The last pixel of a window is not written back.

Counters:
- On Acc, if col == W-1: col goes to 0 and row increments. Otherwise col increments.
- Counters hold when there is no Acc; bubbles are allowed at any position.

Output and completion:
- Out_Valid is registered. It is 1 in the cycle after an Acc where row[0] & col[0], and 0 otherwise.
- On an Acc with col == W-1 and row == H-1, go to state DONE.

State DONE (one cycle):
- Done = 1, Busy = 0, In_Ready = 0.
- Out_Valid for the last window is asserted in this same cycle.
- Next state IDLE; col and row cleared.
- A Start in DONE is ignored.

Throughput and limits:
- One pixel per clock; no output backpressure.
- Outputs per frame = (W/2)*(H/2).
- Counters never exceed W-1 / H-1.

Reset mid-frame:
- Immediate return to reset values.
- No Done pulse; a pending Out_Valid is dropped.

Test Plan:
- W=4, H=4, Start, 16 back-to-back pixels indices 0..15 -> Out_Valid high in the cycle after indices 5, 7, 13, 15 (four pulses). Done coincides with the last Out_Valid. Busy is high from the cycle after Start until DONE.
- Same 4x4 frame with In_Valid deasserted every third cycle -> the same four windows, each Out_Valid one cycle after its triggering Acc. Counters hold during bubbles.
- Lb_Addr/Win_Load check on the same 4x4 frame:
  - Lb_Addr sequence per row is 0,0,1,1.
  - Win_Load=1 only at indices 0 and 2 of row 0 and indices 8 and 10 of row 2.
  - Lb_Wr_En=0 only at indices 5, 7, 13, 15.
- Start with W=3, H=4, then W=0, then H=1 -> a Cfg_Err pulse each time, Busy stays 0, In_Ready stays 0.
- W=2, H=2 -> exactly one Out_Valid, after the 4th pixel, with Done in the same cycle. Start asserted during RUN with W=8 does not change the frame length.
- 4x4 frame with Rst low after pixel 9 -> all outputs 0 immediately and no Done. A new Start with W=2, H=2 then completes normally with 1 output.
